// File: rtl/instr_mem_pkg.sv
// Shared types and encodings for the memory-access pipeline stage.
package instr_mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] HOT_NONE  = 3'b000;
  localparam logic [2:0] HOT_ARITH = 3'b100;
  localparam logic [2:0] HOT_MEM   = 3'b010;
  localparam logic [2:0] HOT_MOVE  = 3'b001;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instruct;
    logic [1:0]      regwrite;
    logic [2:0]      reg_wb_enc;
    logic [XLEN-1:0] memory_wb_data;
    logic [XLEN-1:0] arithmetic_result;
    logic [XLEN-1:0] operand_val2;
    logic [2:0]      data_select_hotcode;
  } mem_wb_t;

endpackage

// File: rtl/instr_mem_lane_align.sv
// Combinational byte-lane steering: store replication/byte enables, load extraction, alignment check.
module instr_mem_lane_align
  import instr_mem_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] store_val,
  input  logic [XLEN-1:0] rdata,
  output logic            aligned_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] load_data_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    aligned_c   = 1'b1;
    wdata_c     = store_val;
    be_c        = 4'b1111;
    load_data_c = rdata;
    byte_v      = rdata[{addr_lo, 3'b000} +: 8];
    half_v      = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: begin
        wdata_c     = {4{store_val[7:0]}};
        be_c        = 4'b0001 << addr_lo;
        load_data_c = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SIZE_HALF: begin
        aligned_c   = ~addr_lo[0];
        wdata_c     = {2{store_val[15:0]}};
        be_c        = 4'b0011 << addr_lo;
        load_data_c = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      end
      // word and the reserved 11 encoding behave identically
      default: aligned_c = (addr_lo == 2'b00);
    endcase
  end

endmodule

// File: rtl/instr_mem.sv
// MEM pipeline stage: data-memory req/ack access, stall, timeout/misalign abort, MEM/WB register.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] ex_mem_instruct,
  input  logic [1:0]      ex_mem_regwrite,
  input  logic [2:0]      ex_mem_reg_wb_enc,
  input  logic [XLEN-1:0] ex_mem_arithmetic_result,
  input  logic [XLEN-1:0] ex_mem_operand_val2,
  input  logic [2:0]      ex_mem_data_select_hotcode,
  input  logic            ex_mem_mem_read,
  input  logic            ex_mem_mem_write,
  input  logic [1:0]      ex_mem_mem_size,
  input  logic            ex_mem_mem_unsigned,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            mem_fault,
  output logic [XLEN-1:0] wb_instruct,
  output logic [1:0]      mem_wb_regwrite,
  output logic [2:0]      mem_wb_reg_wb_enc,
  output logic [XLEN-1:0] mem_wb_reg_memory_wb_data,
  output logic [XLEN-1:0] mem_wb_reg_arithmetic_result,
  output logic [XLEN-1:0] mem_wb_reg_operand_val2,
  output logic [2:0]      mem_wb_reg_data_select_hotcode
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  mem_wb_t         mem_wb, mem_wb_nx;
  logic            fault_nx;

  logic            mem_op_c, aligned_c, req_c, abort_c, stall_c;
  logic [XLEN-1:0] wdata_c, load_data_c;
  logic [3:0]      be_c;

  instr_mem_lane_align u_lane_align (
    .addr_lo     (ex_mem_arithmetic_result[1:0]),
    .size        (ex_mem_mem_size),
    .is_unsigned (ex_mem_mem_unsigned),
    .store_val   (ex_mem_operand_val2),
    .rdata       (dmem_rdata),
    .aligned_c   (aligned_c),
    .wdata_c     (wdata_c),
    .be_c        (be_c),
    .load_data_c (load_data_c)
  );

  // Request is gated by resetn so an asserted reset drops it without waiting for an edge.
  assign mem_op_c = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
  assign req_c    = resetn & mem_op_c & aligned_c;
  assign abort_c  = req_c & (state == ST_WAIT) & (cnt == CNT_LAST) & ~dmem_ack;
  assign stall_c  = req_c & ~dmem_ack & ~abort_c;

  assign dmem_req   = req_c;
  assign dmem_we    = req_c & ex_mem_mem_write;
  assign dmem_addr  = req_c ? {ex_mem_arithmetic_result[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = req_c ? wdata_c : '0;
  assign dmem_be    = req_c ? be_c : 4'b0000;
  assign mem_stall  = stall_c;

  // State, timeout counter and MEM/WB register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_wb    <= '0;
      mem_fault <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mem_wb    <= mem_wb_nx;
      mem_fault <= fault_nx;
    end
  end

  // Next state, counter, fault and MEM/WB payload; bubble unless the instruction completes.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    mem_wb_nx = '0;
    fault_nx  = (mem_op_c & ~aligned_c) | abort_c;

    case (state)
      ST_IDLE: begin
        if (req_c && !dmem_ack) begin
          state_nx = ST_WAIT;
          cnt_nx   = '0;
        end
      end
      ST_WAIT: begin
        if (!req_c || dmem_ack || abort_c) state_nx = ST_IDLE;
        else                               cnt_nx   = cnt + CNT_W'(1);
      end
      default: state_nx = ST_IDLE;
    endcase

    if (ex_mem_valid && !stall_c && !fault_nx) begin
      mem_wb_nx.instruct            = ex_mem_instruct;
      mem_wb_nx.regwrite            = ex_mem_regwrite;
      mem_wb_nx.reg_wb_enc          = ex_mem_reg_wb_enc;
      mem_wb_nx.memory_wb_data      = ex_mem_mem_read ? load_data_c : '0;
      mem_wb_nx.arithmetic_result   = ex_mem_arithmetic_result;
      mem_wb_nx.operand_val2        = ex_mem_operand_val2;
      mem_wb_nx.data_select_hotcode = ex_mem_data_select_hotcode;
    end
  end

  assign wb_instruct                    = mem_wb.instruct;
  assign mem_wb_regwrite                = mem_wb.regwrite;
  assign mem_wb_reg_wb_enc              = mem_wb.reg_wb_enc;
  assign mem_wb_reg_memory_wb_data      = mem_wb.memory_wb_data;
  assign mem_wb_reg_arithmetic_result   = mem_wb.arithmetic_result;
  assign mem_wb_reg_operand_val2        = mem_wb.operand_val2;
  assign mem_wb_reg_data_select_hotcode = mem_wb.data_select_hotcode;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem with TIMEOUT=4 and hand-computed expectations.
module tb_instr_mem;
  import instr_mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_instruct;
  logic [1:0]  ex_mem_regwrite;
  logic [2:0]  ex_mem_reg_wb_enc;
  logic [31:0] ex_mem_arithmetic_result;
  logic [31:0] ex_mem_operand_val2;
  logic [2:0]  ex_mem_data_select_hotcode;
  logic        ex_mem_mem_read, ex_mem_mem_write;
  logic [1:0]  ex_mem_mem_size;
  logic        ex_mem_mem_unsigned;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, mem_fault;
  logic [31:0] wb_instruct;
  logic [1:0]  mem_wb_regwrite;
  logic [2:0]  mem_wb_reg_wb_enc;
  logic [31:0] mem_wb_reg_memory_wb_data, mem_wb_reg_arithmetic_result, mem_wb_reg_operand_val2;
  logic [2:0]  mem_wb_reg_data_select_hotcode;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_mem #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .ex_mem_valid(ex_mem_valid), .ex_mem_instruct(ex_mem_instruct),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_reg_wb_enc(ex_mem_reg_wb_enc),
    .ex_mem_arithmetic_result(ex_mem_arithmetic_result), .ex_mem_operand_val2(ex_mem_operand_val2),
    .ex_mem_data_select_hotcode(ex_mem_data_select_hotcode),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
    .ex_mem_mem_size(ex_mem_mem_size), .ex_mem_mem_unsigned(ex_mem_mem_unsigned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault), .wb_instruct(wb_instruct),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_reg_wb_enc(mem_wb_reg_wb_enc),
    .mem_wb_reg_memory_wb_data(mem_wb_reg_memory_wb_data),
    .mem_wb_reg_arithmetic_result(mem_wb_reg_arithmetic_result),
    .mem_wb_reg_operand_val2(mem_wb_reg_operand_val2),
    .mem_wb_reg_data_select_hotcode(mem_wb_reg_data_select_hotcode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic valid, input logic [31:0] instr, input logic [1:0] rw,
                        input logic [2:0] enc, input logic [31:0] arith, input logic [31:0] val2,
                        input logic [2:0] hot, input logic rd, input logic wr,
                        input logic [1:0] size, input logic uns);
    ex_mem_valid = valid; ex_mem_instruct = instr; ex_mem_regwrite = rw;
    ex_mem_reg_wb_enc = enc; ex_mem_arithmetic_result = arith; ex_mem_operand_val2 = val2;
    ex_mem_data_select_hotcode = hot; ex_mem_mem_read = rd; ex_mem_mem_write = wr;
    ex_mem_mem_size = size; ex_mem_mem_unsigned = uns;
    #1;
  endtask

  task automatic idle_op();
    set_op(1'b0, 32'h0, 2'b00, 3'd0, 32'h0, 32'h0, HOT_NONE, 1'b0, 1'b0, SIZE_WORD, 1'b0);
  endtask

  initial begin
    resetn = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    idle_op();
    #12;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    chk("rst_regwrite", 32'(mem_wb_regwrite), 32'd0);
    chk("rst_arith", mem_wb_reg_arithmetic_result, 32'h0);
    tick();
    resetn = 1'b1;
    tick();

    // ADD r3: pass-through, no memory traffic
    set_op(1'b1, 32'h0033_01B3, 2'b01, 3'd3, 32'h0000_0042, 32'h5, HOT_ARITH, 1'b0, 1'b0, SIZE_WORD, 1'b0);
    chk("add_req", 32'(dmem_req), 32'd0);
    chk("add_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("add_arith", mem_wb_reg_arithmetic_result, 32'h42);
    chk("add_regwrite", 32'(mem_wb_regwrite), 32'd1);
    chk("add_enc", 32'(mem_wb_reg_wb_enc), 32'd3);
    chk("add_hot", 32'(mem_wb_reg_data_select_hotcode), 32'(HOT_ARITH));
    chk("add_instr", wb_instruct, 32'h0033_01B3);
    chk("add_memdata", mem_wb_reg_memory_wb_data, 32'h0);

    // LB signed 0x1003, ack same cycle
    set_op(1'b1, 32'h0000_1103, 2'b01, 3'd4, 32'h0000_1003, 32'h0, HOT_MEM, 1'b1, 1'b0, SIZE_BYTE, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234; #1;
    chk("lb_req", 32'(dmem_req), 32'd1);
    chk("lb_we", 32'(dmem_we), 32'd0);
    chk("lb_addr", dmem_addr, 32'h0000_1000);
    chk("lb_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("lb_data", mem_wb_reg_memory_wb_data, 32'hFFFF_FF80);
    chk("lb_hot", 32'(mem_wb_reg_data_select_hotcode), 32'(HOT_MEM));

    // LHU 0x1002, ack after 3 stall cycles
    set_op(1'b1, 32'h0000_2203, 2'b01, 3'd5, 32'h0000_1002, 32'h0, HOT_MEM, 1'b1, 1'b0, SIZE_HALF, 1'b1);
    dmem_ack = 1'b0; dmem_rdata = 32'h0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lhu_stall", 32'(mem_stall), 32'd1);
      tick();
      chk("lhu_bubble_rw", 32'(mem_wb_regwrite), 32'd0);
      chk("lhu_bubble_hot", 32'(mem_wb_reg_data_select_hotcode), 32'(HOT_NONE));
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000; #1;
    chk("lhu_stall_ack", 32'(mem_stall), 32'd0);
    tick();
    chk("lhu_data", mem_wb_reg_memory_wb_data, 32'h0000_8001);
    chk("lhu_regwrite", 32'(mem_wb_regwrite), 32'd1);

    // SB 0x2001
    set_op(1'b1, 32'h0000_3323, 2'b00, 3'd0, 32'h0000_2001, 32'h0000_00AB, HOT_MEM, 1'b0, 1'b1, SIZE_BYTE, 1'b0);
    chk("sb_be", 32'(dmem_be), 32'b0010);
    chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem_addr, 32'h0000_2000);
    chk("sb_we", 32'(dmem_we), 32'd1);
    tick();
    chk("sb_memdata", mem_wb_reg_memory_wb_data, 32'h0);
    chk("sb_val2", mem_wb_reg_operand_val2, 32'h0000_00AB);

    // SH 0x2002
    set_op(1'b1, 32'h0000_4423, 2'b00, 3'd0, 32'h0000_2002, 32'h0000_1234, HOT_MEM, 1'b0, 1'b1, SIZE_HALF, 1'b0);
    chk("sh_be", 32'(dmem_be), 32'b1100);
    chk("sh_wdata", dmem_wdata, 32'h1234_1234);
    tick();

    // LW misaligned 0x3002
    dmem_ack = 1'b0;
    set_op(1'b1, 32'h0000_5503, 2'b01, 3'd6, 32'h0000_3002, 32'h0, HOT_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("mis_fault", 32'(mem_fault), 32'd1);
    chk("mis_regwrite", 32'(mem_wb_regwrite), 32'd0);
    idle_op();
    tick();
    chk("mis_fault_pulse", 32'(mem_fault), 32'd0);

    // LW 0x4000, never acked: 4 stall cycles, abort in 4th WAIT cycle
    set_op(1'b1, 32'h0000_6603, 2'b01, 3'd7, 32'h0000_4000, 32'h0, HOT_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    chk("to_release", 32'(mem_stall), 32'd0);
    chk("to_fault_early", 32'(mem_fault), 32'd0);
    tick();
    idle_op();
    chk("to_fault", 32'(mem_fault), 32'd1);
    chk("to_regwrite", 32'(mem_wb_regwrite), 32'd0);
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    tick();

    // LW 0x4004 acked on the last allowed WAIT cycle
    set_op(1'b1, 32'h0000_7703, 2'b01, 3'd2, 32'h0000_4004, 32'h0, HOT_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; #1;
    chk("late_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("late_data", mem_wb_reg_memory_wb_data, 32'hDEAD_BEEF);
    chk("late_fault", 32'(mem_fault), 32'd0);
    dmem_ack = 1'b0;

    // LW 0x5000, reset asserted while in WAIT
    set_op(1'b1, 32'h0000_8803, 2'b01, 3'd1, 32'h0000_5000, 32'h0, HOT_MEM, 1'b1, 1'b0, SIZE_WORD, 1'b0);
    tick();
    tick();
    chk("rw_stall", 32'(mem_stall), 32'd1);
    resetn = 1'b0; #1;
    chk("rw_req", 32'(dmem_req), 32'd0);
    chk("rw_stall_drop", 32'(mem_stall), 32'd0);
    chk("rw_addr", dmem_addr, 32'h0);
    chk("rw_regwrite", 32'(mem_wb_regwrite), 32'd0);
    chk("rw_memdata", mem_wb_reg_memory_wb_data, 32'h0);
    chk("rw_fault", 32'(mem_fault), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
